// File: rtl/sync_fifo_mode_pkg.sv
// Shared FIFO definitions: full-handling mode codes and parameter helpers.
// Imported by every app-block FIFO instantiation.
package sync_fifo_mode_pkg;

  localparam int FIFO_MODE_BACKPRESSURE = 0;
  localparam int FIFO_MODE_DROP         = 1;
  localparam int FIFO_MODE_OVERWRITE    = 2;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mode_ram.sv
// Simple dual-port storage for sync_fifo_mode.
// Synchronous write, asynchronous read, no reset.
module fifo_ram_sdp #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_mode.sv
// Single-clock FWFT FIFO with selectable full handling
// (backpressure, drop newest, overwrite oldest).
module sync_fifo_mode
  import sync_fifo_mode_pkg::*;
#(
  parameter int WIDTH      = 512,
  parameter int DEPTH      = 64,
  parameter int FULL_MODE  = FIFO_MODE_BACKPRESSURE,
  parameter int AF_THRESH  = DEPTH - 4,
  parameter int AE_THRESH  = 4,
  parameter int DROP_CNT_W = 16,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int CNT_W     = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_mode: DEPTH must be a power of 2 and >= 2");
  end
  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("sync_fifo_mode: need AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (FULL_MODE < 0 || FULL_MODE > 2) begin : g_bad_mode
    $error("sync_fifo_mode: FULL_MODE must be 0, 1 or 2");
  end

  localparam logic [CNT_W-1:0] AF_LVL = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] P_ONE  = CNT_W'(1);
  localparam logic [DROP_CNT_W-1:0] D_ONE = DROP_CNT_W'(1);
  localparam bit BP = (FULL_MODE == FIFO_MODE_BACKPRESSURE);
  localparam bit OW = (FULL_MODE == FIFO_MODE_OVERWRITE);
  localparam bit DR = (FULL_MODE == FIFO_MODE_DROP);

  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;
  logic ovf;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign s_ready      = BP ? !full : 1'b1;
  assign m_valid      = !empty;

  // A pop frees the slot the push needs, so full only matters without a pop.
  always_comb begin
    push   = s_valid & s_ready;
    pop    = !empty & m_ready;
    wr_en  = 1'b0;
    rd_adv = pop;
    ovf    = 1'b0;
    if (push) begin
      if (!full || pop) begin
        wr_en = 1'b1;
      end else if (OW) begin
        wr_en  = 1'b1;
        rd_adv = 1'b1;
        ovf    = 1'b1;
      end else if (DR) begin
        ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + P_ONE;
      if (rd_adv) rd_ptr <= rd_ptr + P_ONE;
      overflow <= ovf;
      if (ovf && drop_count != '1) drop_count <= drop_count + D_ONE;
    end
  end

  fifo_ram_sdp #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en & !flush),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (s_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (m_data)
  );

endmodule

// File: tb/tb_sync_fifo_mode.sv
// Directed bench: one DEPTH=8 FIFO per full-handling mode,
// hand-computed expectations for order, overflow, flush and reset.
module tb_sync_fifo_mode;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_valid [3];
  logic       s_ready [3];
  logic [7:0] m_data [3];
  logic       m_valid [3];
  logic       m_ready [3];
  logic [3:0] count [3];
  logic       almost_full [3];
  logic       almost_empty [3];
  logic       overflow [3];
  logic [7:0] drop_count [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sync_fifo_mode #(
      .WIDTH      (8),
      .DEPTH      (8),
      .FULL_MODE  (g),
      .AF_THRESH  (6),
      .AE_THRESH  (2),
      .DROP_CNT_W (8)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .s_data       (s_data),
      .s_valid      (s_valid[g]),
      .s_ready      (s_ready[g]),
      .m_data       (m_data[g]),
      .m_valid      (m_valid[g]),
      .m_ready      (m_ready[g]),
      .count        (count[g]),
      .almost_full  (almost_full[g]),
      .almost_empty (almost_empty[g]),
      .overflow     (overflow[g]),
      .drop_count   (drop_count[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int m, input logic [7:0] d);
    s_valid[m] = 1'b1;
    s_data     = d;
    step();
    s_valid[m] = 1'b0;
  endtask

  task automatic pop_chk(input int m, input logic [7:0] exp);
    chk("pop_valid", 32'(m_valid[m]), 1);
    chk("pop_data", 32'(m_data[m]), 32'(exp));
    m_ready[m] = 1'b1;
    step();
    m_ready[m] = 1'b0;
  endtask

  initial begin
    for (int m = 0; m < 3; m++) begin
      s_valid[m] = 1'b0;
      m_ready[m] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
    step();

    // reset state
    for (int m = 0; m < 3; m++) begin
      chk("rst_count", 32'(count[m]), 0);
      chk("rst_mvalid", 32'(m_valid[m]), 0);
      chk("rst_sready", 32'(s_ready[m]), 1);
      chk("rst_ae", 32'(almost_empty[m]), 1);
      chk("rst_af", 32'(almost_full[m]), 0);
      chk("rst_ovf", 32'(overflow[m]), 0);
      chk("rst_drop", 32'(drop_count[m]), 0);
    end

    // mode 0: fill then drain
    for (int i = 0; i < 8; i++) begin
      chk("m0_sready_fill", 32'(s_ready[0]), 1);
      push(0, 8'(i));
    end
    chk("m0_sready_full", 32'(s_ready[0]), 0);
    chk("m0_count_full", 32'(count[0]), 8);
    chk("m0_af_full", 32'(almost_full[0]), 1);
    chk("m0_ae_full", 32'(almost_empty[0]), 0);
    for (int i = 0; i < 8; i++) pop_chk(0, 8'(i));
    chk("m0_mvalid_empty", 32'(m_valid[0]), 0);
    chk("m0_count_empty", 32'(count[0]), 0);

    // mode 0: steady push+pop at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) push(0, 8'(i));
    for (int i = 0; i < 100; i++) begin
      chk("m0_stream_data", 32'(m_data[0]), 32'(i));
      chk("m0_stream_count", 32'(count[0]), 3);
      s_data     = 8'(i + 3);
      s_valid[0] = 1'b1;
      m_ready[0] = 1'b1;
      step();
    end
    s_valid[0] = 1'b0;
    m_ready[0] = 1'b0;
    for (int i = 100; i < 103; i++) pop_chk(0, 8'(i));
    chk("m0_stream_end", 32'(m_valid[0]), 0);

    // mode 1: drop newest when full
    for (int i = 0; i < 8; i++) push(1, 8'(i));
    chk("m1_sready_full", 32'(s_ready[1]), 1);
    push(1, 8'hAA);
    chk("m1_ovf_pulse", 32'(overflow[1]), 1);
    chk("m1_drop1", 32'(drop_count[1]), 1);
    chk("m1_count", 32'(count[1]), 8);
    step();
    chk("m1_ovf_clear", 32'(overflow[1]), 0);
    for (int i = 0; i < 8; i++) pop_chk(1, 8'(i));
    chk("m1_empty", 32'(m_valid[1]), 0);

    // mode 2: overwrite oldest when full
    for (int i = 0; i < 8; i++) push(2, 8'(i));
    push(2, 8'd8);
    chk("m2_ovf_a", 32'(overflow[2]), 1);
    push(2, 8'd9);
    chk("m2_ovf_b", 32'(overflow[2]), 1);
    chk("m2_drop2", 32'(drop_count[2]), 2);
    chk("m2_count", 32'(count[2]), 8);
    step();
    chk("m2_ovf_clear", 32'(overflow[2]), 0);
    for (int i = 2; i < 10; i++) pop_chk(2, 8'(i));
    chk("m2_empty", 32'(m_valid[2]), 0);

    // full with simultaneous push+pop: no overflow in modes 1 and 2
    for (int m = 1; m < 3; m++) begin
      for (int i = 0; i < 8; i++) push(m, 8'(i));
      chk("pp_head_before", 32'(m_data[m]), 0);
      s_data     = 8'h10 + 8'(m);
      s_valid[m] = 1'b1;
      m_ready[m] = 1'b1;
      step();
      s_valid[m] = 1'b0;
      m_ready[m] = 1'b0;
      chk("pp_ovf", 32'(overflow[m]), 0);
      chk("pp_count", 32'(count[m]), 8);
      chk("pp_head_after", 32'(m_data[m]), 1);
      chk("pp_drop", 32'(drop_count[m]), 32'(m));
    end

    // flush with concurrent push at count 5
    for (int i = 1; i < 4; i++) pop_chk(2, 8'(i));
    chk("fl_count_pre", 32'(count[2]), 5);
    flush      = 1'b1;
    s_valid[2] = 1'b1;
    s_data     = 8'h55;
    step();
    flush      = 1'b0;
    s_valid[2] = 1'b0;
    chk("fl_count", 32'(count[2]), 0);
    chk("fl_mvalid", 32'(m_valid[2]), 0);
    chk("fl_drop", 32'(drop_count[2]), 2);
    chk("fl_ovf", 32'(overflow[2]), 0);
    chk("fl_ae", 32'(almost_empty[2]), 1);
    step();
    chk("fl_stays_empty", 32'(m_valid[2]), 0);

    // async reset in the middle of a burst
    s_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = 8'(8'h70 + i);
      step();
    end
    chk("burst_count", 32'(count[0]), 3);
    rst = 1'b1;
    #1;
    chk("arst_count", 32'(count[0]), 0);
    chk("arst_mvalid", 32'(m_valid[0]), 0);
    chk("arst_sready", 32'(s_ready[0]), 1);
    chk("arst_drop1", 32'(drop_count[1]), 0);
    chk("arst_drop2", 32'(drop_count[2]), 0);
    chk("arst_ae", 32'(almost_empty[0]), 1);
    s_valid[0] = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_count", 32'(count[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
